router_pkt_tx: RTL and testbench

//  Source-side packet transmitter for the 1x3 router. It drives the router input port (data, pkt_valid)
//  and honours the router's busy. Host software queues payload bytes in an internal FIFO, then issues a

---
 rtl/router_pkt_tx.sv | 205 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Brief    : Router source port: queues payload, sends {len,addr} header, payload, parity.
// Revision : 1.0
// ============================================================================
module router_pkt_tx #(
    parameter int DEPTH      = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        wr_full,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic        cmd_corrupt,
    output logic        cmd_ready,
    output logic        cmd_err,
    input  logic        busy,
    output logic [7:0]  data_out,
    output logic        pkt_valid,
    output logic        tx_done,
    output logic [15:0] pkt_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HDR  = 3'd2,
        S_PLD  = 3'd3,
        S_PAR  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                r_wr_full;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    logic [1:0]          r_addr;
    logic [5:0]          r_len;
    logic                r_corrupt;
    logic [5:0]          r_byte_cnt;
    logic [7:0]          r_parity;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_cmd_ready;
    logic                r_cmd_err;
    logic [7:0]          r_data_out;
    logic                r_pkt_valid;
    logic                r_tx_done;
    logic [15:0]         r_pkt_cnt;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign w_push = wr_en && (r_count != c_DEPTH);
    assign w_pop  = !busy && ((r_state == S_HDR) ||
                              ((r_state == S_PLD) && (r_byte_cnt < r_len)));
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count   <= w_count_next;
            r_wr_full <= (w_count_next == c_DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= 2'd0;
            r_len       <= 6'd0;
            r_corrupt   <= 1'b0;
            r_byte_cnt  <= 6'd0;
            r_parity    <= 8'd0;
            r_gap_cnt   <= '0;
            r_cmd_ready <= 1'b1;
            r_cmd_err   <= 1'b0;
            r_data_out  <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_tx_done   <= 1'b0;
            r_pkt_cnt   <= 16'd0;
        end else begin
            r_cmd_err <= 1'b0;
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        if ((cmd_addr == 2'd3) || (cmd_len == 6'd0)) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_addr      <= cmd_addr;
                            r_len       <= cmd_len;
                            r_corrupt   <= cmd_corrupt;
                            r_cmd_ready <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                // Header only goes out once the whole payload is queued, so
                // pkt_valid can never drop mid-payload for lack of data.
                S_WAIT: begin
                    if (r_count >= c_CNT_W'(r_len)) begin
                        r_data_out  <= {r_len, r_addr};
                        r_parity    <= {r_len, r_addr};
                        r_pkt_valid <= 1'b1;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        r_data_out <= w_head;
                        r_parity   <= r_parity ^ w_head;
                        r_byte_cnt <= 6'd1;
                        r_state    <= S_PLD;
                    end
                end
                S_PLD: begin
                    if (!busy) begin
                        if (r_byte_cnt < r_len) begin
                            r_data_out <= w_head;
                            r_parity   <= r_parity ^ w_head;
                            r_byte_cnt <= r_byte_cnt + 6'd1;
                        end else begin
                            r_data_out  <= r_parity ^ {7'd0, r_corrupt};
                            r_pkt_valid <= 1'b0;
                            r_state     <= S_PAR;
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        r_data_out <= 8'd0;
                        r_tx_done  <= 1'b1;
                        r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                        r_gap_cnt  <= '0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                default: begin
                    r_pkt_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_full   = r_wr_full;
    assign cmd_ready = r_cmd_ready;
    assign cmd_err   = r_cmd_err;
    assign data_out  = r_data_out;
    assign pkt_valid = r_pkt_valid;
    assign tx_done   = r_tx_done;
    assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Brief    : Self-checking bench for router_pkt_tx: vector table, corner sequences, random traffic.
// Revision : 1.0
// ============================================================================
module tb_router_pkt_tx;

    localparam int c_DEPTH = 64;
    localparam int c_GAP   = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_full;
    logic        cmd_valid;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        cmd_corrupt;
    logic        cmd_ready;
    logic        cmd_err;
    logic        busy;
    logic [7:0]  data_out;
    logic        pkt_valid;
    logic        tx_done;
    logic [15:0] pkt_cnt;

    router_pkt_tx #(.DEPTH(c_DEPTH), .GAP_CYCLES(c_GAP)) dut (
        .clock(clock), .resetn(resetn),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_corrupt(cmd_corrupt), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
        .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid),
        .tx_done(tx_done), .pkt_cnt(pkt_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    // Reference model: FIFO contents as a queue, expected byte stream per packet.
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       gv_q[$];

    logic [7:0] hold_byte = 8'h00;
    int         hold_left = 0;
    int         hold_seen = 0;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       corrupt;
        logic       exp_err;
        logic [7:0] exp_hdr;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (model_q.size() < c_DEPTH) model_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] a, input logic [5:0] l, input logic c);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_addr    = a;
        cmd_len     = l;
        cmd_corrupt = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic build_expected(input logic [1:0] a, input logic [5:0] l, input logic c);
        logic [7:0] p;
        exp_q.delete();
        p = {l, a};
        exp_q.push_back(p);
        for (int i = 0; i < int'(l); i++) begin
            logic [7:0] b;
            b = model_q.pop_front();
            exp_q.push_back(b);
            p = p ^ b;
        end
        exp_q.push_back(p ^ {7'd0, c});
    endtask

    // Records every consumed byte until the parity byte is taken.
    task automatic collect(input int busy_pct, input int push_pct);
        bit in_par  = 1'b0;
        bit prev_pv = 1'b0;
        bit done    = 1'b0;
        bit consumed;
        got_q.delete();
        gv_q.delete();
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (prev_pv && !pkt_valid) in_par = 1'b1;
            if (pkt_valid && data_out == hold_byte) hold_seen++;
            if (hold_left > 0 && pkt_valid && data_out == hold_byte) begin
                busy = 1'b1;
                hold_left--;
            end else begin
                busy = (int'($urandom_range(99)) < busy_pct);
            end
            wr_en = 1'b0;
            if (push_pct > 0 && model_q.size() < 30 && int'($urandom_range(99)) < push_pct) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                model_q.push_back(wr_data);
            end
            consumed = !busy && (pkt_valid || in_par);
            if (consumed) begin
                got_q.push_back(data_out);
                gv_q.push_back(pkt_valid);
            end
            prev_pv = pkt_valid;
            tick();
            if (consumed && in_par) done = 1'b1;
        end
        busy  = 1'b0;
        wr_en = 1'b0;
        check("pkt_complete", 32'(done), 32'd1);
        if (done) begin
            exp_cnt++;
            check("tx_done_pulse", 32'(tx_done), 32'd1);
            check("data_after_par", 32'(data_out), 32'd0);
            check("pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_cnt)));
        end
    endtask

    task automatic compare_pkt(input string tag);
        check($sformatf("%s_nbytes", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            check($sformatf("%s_pv%0d", tag, i), 32'(gv_q[i]),
                  (i == exp_q.size() - 1) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit         any_pv;
        int         gap;
        int         n;
        logic [7:0] xr;

        vecs[0] = '{2'd3, 6'd5,  1'b0, 1'b1, 8'h00};
        vecs[1] = '{2'd0, 6'd0,  1'b0, 1'b1, 8'h00};
        vecs[2] = '{2'd3, 6'd0,  1'b1, 1'b1, 8'h00};
        vecs[3] = '{2'd1, 6'd3,  1'b0, 1'b0, 8'h0D};
        vecs[4] = '{2'd2, 6'd4,  1'b1, 1'b0, 8'h12};
        vecs[5] = '{2'd0, 6'd1,  1'b0, 1'b0, 8'h04};
        vecs[6] = '{2'd2, 6'd63, 1'b1, 1'b0, 8'hFE};
        vecs[7] = '{2'd1, 6'd6,  1'b1, 1'b0, 8'h19};

        resetn = 1'b0; wr_en = 1'b0; wr_data = 8'd0; cmd_valid = 1'b0;
        cmd_addr = 2'd0; cmd_len = 6'd0; cmd_corrupt = 1'b0; busy = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_full",   32'(wr_full),   32'd0);
        check("rst_cmd_err",   32'(cmd_err),   32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_tx_done",   32'(tx_done),   32'd0);
        check("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
        resetn = 1'b1;
        tick();

        // T1: basic packet and gap length
        push(8'h11); push(8'h22); push(8'h33);
        issue(2'd1, 6'd3, 1'b0);
        build_expected(2'd1, 6'd3, 1'b0);
        collect(0, 0);
        compare_pkt("T1");
        if (got_q.size() == 5) check("T1_parity", 32'(got_q[4]), 32'h0D);
        gap = 0;
        while (!cmd_ready && gap < 10) begin
            check("gap_pkt_valid", 32'(pkt_valid), 32'd0);
            gap++;
            tick();
        end
        check("T1_gap_cycles", 32'(gap), 32'(c_GAP));

        // T2: busy holds 0x22 for three cycles
        push(8'h11); push(8'h22); push(8'h33);
        hold_byte = 8'h22; hold_left = 3; hold_seen = 0;
        issue(2'd1, 6'd3, 1'b0);
        build_expected(2'd1, 6'd3, 1'b0);
        collect(0, 0);
        compare_pkt("T2");
        check("T2_hold_cycles", 32'(hold_seen), 32'd4);
        hold_left = 0; hold_byte = 8'h00;

        // Vector table; queued bytes must survive the rejected requests
        push(8'hA5); push(8'h5A);
        foreach (vecs[k]) begin
            if (vecs[k].exp_err) begin
                issue(vecs[k].addr, vecs[k].len, vecs[k].corrupt);
                check($sformatf("V%0d_cmd_err", k),   32'(cmd_err),   32'd1);
                check($sformatf("V%0d_cmd_ready", k), 32'(cmd_ready), 32'd1);
                check($sformatf("V%0d_pkt_valid", k), 32'(pkt_valid), 32'd0);
                tick();
                check($sformatf("V%0d_err_pulse", k), 32'(cmd_err),   32'd0);
            end else begin
                while (model_q.size() < int'(vecs[k].len)) push(8'($urandom));
                issue(vecs[k].addr, vecs[k].len, vecs[k].corrupt);
                check($sformatf("V%0d_no_err", k), 32'(cmd_err), 32'd0);
                build_expected(vecs[k].addr, vecs[k].len, vecs[k].corrupt);
                collect(0, 0);
                if (got_q.size() > 0) check($sformatf("V%0d_hdr", k), 32'(got_q[0]), 32'(vecs[k].exp_hdr));
                compare_pkt($sformatf("V%0d", k));
            end
        end

        // T4: wait for payload to arrive
        push(8'h41); push(8'h42);
        issue(2'd2, 6'd4, 1'b0);
        any_pv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            any_pv = any_pv | pkt_valid;
            tick();
        end
        check("T4_wait_pv", 32'(any_pv), 32'd0);
        push(8'h43);
        push(8'h44);
        check("T4_pv_at_count4", 32'(pkt_valid), 32'd0);
        tick();
        check("T4_hdr", 32'(data_out), 32'h12);
        check("T4_hdr_pv", 32'(pkt_valid), 32'd1);
        build_expected(2'd2, 6'd4, 1'b0);
        collect(0, 0);
        compare_pkt("T4");

        // T5: full FIFO, dropped push, corrupted parity, leftover byte
        for (int i = 0; i < 63; i++) push(8'(i * 7 + 3));
        check("T5_not_full_63", 32'(wr_full), 32'd0);
        push(8'hC3);
        check("T5_full_64", 32'(wr_full), 32'd1);
        push(8'hEE);
        check("T5_full_after_drop", 32'(wr_full), 32'd1);
        issue(2'd2, 6'd63, 1'b1);
        build_expected(2'd2, 6'd63, 1'b1);
        collect(0, 0);
        compare_pkt("T5");
        xr = 8'h00;
        for (int i = 0; i < exp_q.size() - 1; i++) xr = xr ^ exp_q[i];
        if (got_q.size() == 65) check("T5_parity_inv", 32'(got_q[64]), 32'(xr ^ 8'h01));
        check("T5_not_full_after", 32'(wr_full), 32'd0);
        issue(2'd0, 6'd1, 1'b0);
        build_expected(2'd0, 6'd1, 1'b0);
        collect(0, 0);
        compare_pkt("T5_left");

        // T6: reset in the middle of a payload
        for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
        issue(2'd0, 6'd10, 1'b0);
        n = 0;
        while (!pkt_valid && n < 10) begin
            tick();
            n++;
        end
        check("T6_started", 32'(pkt_valid), 32'd1);
        tick(); tick(); tick();
        resetn = 1'b0;
        tick();
        check("T6_pkt_valid", 32'(pkt_valid), 32'd0);
        check("T6_data_out",  32'(data_out),  32'd0);
        check("T6_wr_full",   32'(wr_full),   32'd0);
        check("T6_cmd_ready", 32'(cmd_ready), 32'd1);
        check("T6_pkt_cnt",   32'(pkt_cnt),   32'd0);
        resetn = 1'b1;
        model_q.delete();
        exp_cnt = 0;
        tick();
        push(8'h9A); push(8'hB7);
        issue(2'd1, 6'd2, 1'b0);
        build_expected(2'd1, 6'd2, 1'b0);
        collect(0, 0);
        compare_pkt("T6_after");

        // Random traffic with busy stalls and concurrent pushes
        for (int p = 0; p < 25; p++) begin
            logic [1:0] a;
            logic [5:0] l;
            logic       c;
            if ($urandom_range(4) == 0) begin
                a = ($urandom_range(1) == 0) ? 2'd3 : 2'($urandom_range(2));
                l = (a == 2'd3) ? 6'($urandom_range(63)) : 6'd0;
                issue(a, l, 1'b0);
                check($sformatf("R%0d_illegal_err", p), 32'(cmd_err), 32'd1);
                tick();
            end
            l = 6'($urandom_range(20, 1));
            a = 2'($urandom_range(2));
            c = 1'($urandom_range(1));
            while (model_q.size() < int'(l)) push(8'($urandom));
            issue(a, l, c);
            build_expected(a, l, c);
            collect(30, 20);
            compare_pkt($sformatf("R%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
